// File: rtl/dram_pkg.sv
// Shared types for the 8-lane byte DRAM request interface, used by the
// responder and by the copy/DMA initiators.
package dram_pkg;

    localparam int NUM_LANES = 8;
    localparam int ADDR_W    = 64;
    localparam int LANE_W    = 8;
    localparam int RSP_W     = 64;

    typedef logic [ADDR_W-1:0] lane_addr_t;
    typedef logic [LANE_W-1:0] lane_byte_t;
    typedef logic [RSP_W-1:0]  lane_rsp_t;

    // Full-width compare; the subtraction is only trusted once addr >= base,
    // so an address below the window can never wrap into range.
    function automatic logic in_range(lane_addr_t addr, lane_addr_t base, lane_addr_t depth);
        return (addr >= base) && ((addr - base) < depth);
    endfunction

endpackage

// File: rtl/dram_lane_responder_if.sv
// Request/response bundle between a DRAM initiator (master) and the lane
// responder (slave).
interface dram_lane_responder_if;
    import dram_pkg::*;

    logic [NUM_LANES-1:0] req_en;
    logic [NUM_LANES-1:0] req_we;
    lane_addr_t           req_addr  [NUM_LANES];
    lane_byte_t           req_wdata [NUM_LANES];
    logic [NUM_LANES-1:0] rsp_valid;
    lane_rsp_t            rsp_data  [NUM_LANES];
    logic [NUM_LANES-1:0] rsp_err;
    logic                 wr_err;
    logic                 busy;

    modport master (
        output req_en, req_we, req_addr, req_wdata,
        input  rsp_valid, rsp_data, rsp_err, wr_err, busy
    );

    modport slave (
        input  req_en, req_we, req_addr, req_wdata,
        output rsp_valid, rsp_data, rsp_err, wr_err, busy
    );

endinterface

// File: rtl/dram_rd_pipe.sv
// One lane's read-return pipeline: READ_LAT stages of {valid, err, data}.
// Data stages only advance behind a valid bit, so the output byte holds.
module dram_rd_pipe
    import dram_pkg::*;
#(
    parameter int READ_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_err,
    input  lane_byte_t in_data,
    output logic       out_valid,
    output logic       out_err,
    output lane_rsp_t  out_data,
    output logic       any_valid
);

    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] err_q;
    lane_byte_t          dat_q [READ_LAT];

    // NOTE: non-blocking assignments here so every stage samples its
    // predecessor's pre-edge value; blocking would collapse the shift chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            err_q <= '0;
            for (int s = 0; s < READ_LAT; s++) dat_q[s] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            err_q[0] <= in_valid & in_err;
            if (in_valid) dat_q[0] <= in_data;
            for (int s = 1; s < READ_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                err_q[s] <= err_q[s-1];
                if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[READ_LAT-1];
    assign out_err   = err_q[READ_LAT-1];
    assign out_data  = RSP_W'(dat_q[READ_LAT-1]);
    assign any_valid = |vld_q;

endmodule

// File: rtl/dram_lane_responder.sv
// Eight-lane byte-addressed scratch DRAM: independent per-lane reads and
// writes, read data returned after a fixed READ_LAT pipeline.
module dram_lane_responder
    import dram_pkg::*;
#(
    parameter int         DEPTH     = 4096,
    parameter lane_addr_t BASE_ADDR = 64'h0,
    parameter int         READ_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dram_lane_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    typedef logic [IDX_W-1:0] idx_t;

    lane_byte_t           mem [DEPTH];
    logic [NUM_LANES-1:0] in_rng;
    logic [NUM_LANES-1:0] rd_req;
    logic [NUM_LANES-1:0] wr_req;
    logic [NUM_LANES-1:0] lane_busy;
    idx_t                 idx     [NUM_LANES];
    lane_byte_t           rd_byte [NUM_LANES];
    logic [NUM_LANES-1:0] rsp_valid;
    logic [NUM_LANES-1:0] rsp_err;
    lane_rsp_t            rsp_data [NUM_LANES];
    logic                 wr_err_q;

    // Reads sample the array before this edge's writes land (read-before-write).
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            in_rng[i]  = in_range(bus.req_addr[i], BASE_ADDR, lane_addr_t'(DEPTH));
            idx[i]     = idx_t'(bus.req_addr[i] - BASE_ADDR);
            rd_req[i]  = bus.req_en[i] & ~bus.req_we[i];
            wr_req[i]  = bus.req_en[i] & bus.req_we[i];
            rd_byte[i] = in_rng[i] ? mem[idx[i]] : '0;
        end
    end

    // NOTE: storage has no reset; contents survive reset and clearing a
    // 4 KiB array would also prevent mapping it onto RAM.
    // Lanes are visited in ascending order, so for colliding writes the last
    // non-blocking update (highest lane) is the one that sticks.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_req[i] && in_rng[i]) mem[idx[i]] <= bus.req_wdata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wr_err_q <= 1'b0;
        else       wr_err_q <= |(wr_req & ~in_rng);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dram_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (rd_req[g]),
            .in_err    (~in_rng[g]),
            .in_data   (rd_byte[g]),
            .out_valid (rsp_valid[g]),
            .out_err   (rsp_err[g]),
            .out_data  (rsp_data[g]),
            .any_valid (lane_busy[g])
        );
        assign bus.rsp_data[g] = rsp_data[g];
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.wr_err    = wr_err_q;
    assign bus.busy      = |lane_busy;

endmodule

// File: tb/tb_dram_lane_responder.sv
// Self-checking bench for dram_lane_responder: directed sequences, a vector
// table and random traffic, all checked against a byte-array/queue model.
module tb_dram_lane_responder;
    import dram_pkg::*;

    localparam int         DEPTH = 4096;
    localparam lane_addr_t BASE  = 64'h0;
    localparam int         LAT   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dram_lane_responder_if bus();

    dram_lane_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        lane_byte_t data;
        logic       err;
    } exp_rsp_t;

    exp_rsp_t   pend [NUM_LANES][$];
    lane_byte_t ref_mem [DEPTH];
    lane_byte_t last_data [NUM_LANES];
    int         wr_err_due = -1;

    logic [NUM_LANES-1:0] st_en, st_we;
    lane_addr_t           st_addr  [NUM_LANES];
    lane_byte_t           st_wdata [NUM_LANES];

    typedef struct {
        logic       we;
        int         lane;
        lane_addr_t addr;
        lane_byte_t wdata;
        lane_byte_t exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    // 128-bit arithmetic so the window end can never wrap.
    function automatic logic ref_in_range(lane_addr_t a);
        logic [127:0] wa, lo;
        wa = {64'b0, a};
        lo = {64'b0, BASE};
        return (wa >= lo) && (wa < lo + 128'(DEPTH));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stage();
        st_en = '0;
        st_we = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            st_addr[i]  = '0;
            st_wdata[i] = '0;
        end
    endtask

    task automatic stage(input int lane, input logic we, input lane_addr_t a, input lane_byte_t d);
        st_en[lane]    = 1'b1;
        st_we[lane]    = we;
        st_addr[lane]  = a;
        st_wdata[lane] = d;
    endtask

    // Drive one cycle of staged requests, update the model, clock, then compare.
    task automatic step(input logic rst);
        logic                 bad_wr;
        logic [NUM_LANES-1:0] ev, ee;
        logic                 eb;
        exp_rsp_t             r;
        reset = rst;
        bus.req_en = st_en;
        bus.req_we = st_we;
        for (int i = 0; i < NUM_LANES; i++) begin
            bus.req_addr[i]  = st_addr[i];
            bus.req_wdata[i] = st_wdata[i];
        end
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                pend[i].delete();
                last_data[i] = '0;
            end
            wr_err_due = -1;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (st_en[i] && !st_we[i]) begin
                    r.due  = cyc + LAT;
                    r.err  = !ref_in_range(st_addr[i]);
                    r.data = r.err ? 8'h00 : ref_mem[int'(st_addr[i] - BASE)];
                    pend[i].push_back(r);
                end
            end
            bad_wr = 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (st_en[i] && st_we[i]) begin
                    if (ref_in_range(st_addr[i])) ref_mem[int'(st_addr[i] - BASE)] = st_wdata[i];
                    else bad_wr = 1'b1;
                end
            end
            wr_err_due = bad_wr ? cyc + 1 : -1;
        end
        @(posedge clk);
        #1;
        cyc++;
        clear_stage();
        ev = '0;
        ee = '0;
        eb = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (pend[i].size() != 0) begin
                eb = 1'b1;
                if (pend[i][0].due == cyc) begin
                    ev[i]        = 1'b1;
                    ee[i]        = pend[i][0].err;
                    last_data[i] = pend[i][0].data;
                    void'(pend[i].pop_front());
                end
            end
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        check("rsp_err", 64'(bus.rsp_err), 64'(ee));
        check("wr_err", 64'(bus.wr_err), 64'(cyc == wr_err_due));
        check("busy", 64'(bus.busy), 64'(eb));
        for (int i = 0; i < NUM_LANES; i++)
            check($sformatf("rsp_data[%0d]", i), bus.rsp_data[i], 64'(last_data[i]));
    endtask

    task automatic wait_lat();
        repeat (LAT - 1) step(1'b0);
    endtask

    initial begin
        lane_addr_t a;
        vecs[0] = '{1'b1, 1, 64'h300, 8'h5A, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 6, 64'h300, 8'h00, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 7, 64'hFFF, 8'hC3, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 2, 64'hFFF, 8'h00, 8'hC3, 1'b0};
        vecs[4] = '{1'b0, 3, 64'h1000, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 4, 64'h1000, 8'h99, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 0, 64'h300, 8'h00, 8'h5A, 1'b0};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int i = 0; i < NUM_LANES; i++) last_data[i] = '0;
        clear_stage();

        // 1: reset, then idle
        step(1'b1);
        step(1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            check("idle_valid", 64'(bus.rsp_valid), 64'h0);
            check("idle_busy", 64'(bus.busy), 64'h0);
        end

        // 2: eight-lane write, then eight-lane read
        for (int i = 0; i < NUM_LANES; i++) stage(i, 1'b1, 64'h100 + 64'(i), 8'h10 + 8'(i));
        step(1'b0);
        for (int i = 0; i < NUM_LANES; i++) stage(i, 1'b0, 64'h100 + 64'(i), 8'h00);
        step(1'b0);
        repeat (LAT - 2) step(1'b0);
        check("t2_not_early", 64'(bus.rsp_valid), 64'h0);
        step(1'b0);
        check("t2_valid", 64'(bus.rsp_valid), 64'hFF);
        check("t2_err", 64'(bus.rsp_err), 64'h0);
        for (int i = 0; i < NUM_LANES; i++)
            check($sformatf("t2_data[%0d]", i), bus.rsp_data[i], 64'h10 + 64'(i));
        step(1'b0);
        check("t2_one_shot", 64'(bus.rsp_valid), 64'h0);

        // 3: read-before-write across lanes
        stage(0, 1'b1, 64'h20, 8'h55);
        step(1'b0);
        stage(0, 1'b1, 64'h20, 8'hAA);
        stage(1, 1'b0, 64'h20, 8'h00);
        step(1'b0);
        wait_lat();
        check("t3_old", bus.rsp_data[1], 64'h55);
        stage(1, 1'b0, 64'h20, 8'h00);
        step(1'b0);
        wait_lat();
        check("t3_new", bus.rsp_data[1], 64'hAA);

        // 4: highest lane wins a write collision
        stage(2, 1'b1, 64'h40, 8'h11);
        stage(5, 1'b1, 64'h40, 8'h22);
        step(1'b0);
        stage(0, 1'b0, 64'h40, 8'h00);
        step(1'b0);
        wait_lat();
        check("t4_winner", bus.rsp_data[0], 64'h22);

        // 5: out-of-range read and write
        stage(3, 1'b0, 64'd4096, 8'h00);
        step(1'b0);
        wait_lat();
        check("t5_valid", 64'(bus.rsp_valid[3]), 64'h1);
        check("t5_err", 64'(bus.rsp_err[3]), 64'h1);
        check("t5_data", bus.rsp_data[3], 64'h0);
        stage(6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h77);
        step(1'b0);
        check("t5_wr_err", 64'(bus.wr_err), 64'h1);
        step(1'b0);
        check("t5_wr_err_pulse", 64'(bus.wr_err), 64'h0);

        // Vector table, one transaction at a time
        for (int v = 0; v < 8; v++) begin
            stage(vecs[v].lane, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            step(1'b0);
            if (vecs[v].we) begin
                check($sformatf("vec%0d_wr_err", v), 64'(bus.wr_err), 64'(vecs[v].exp_err));
            end else begin
                wait_lat();
                check($sformatf("vec%0d_valid", v), 64'(bus.rsp_valid[vecs[v].lane]), 64'h1);
                check($sformatf("vec%0d_err", v), 64'(bus.rsp_err[vecs[v].lane]), 64'(vecs[v].exp_err));
                check($sformatf("vec%0d_data", v), bus.rsp_data[vecs[v].lane], 64'(vecs[v].exp_data));
            end
        end

        // Prefill the random window so every random read hits written bytes
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NUM_LANES; i++)
                stage(i, 1'b1, 64'(8 * k + i), 8'($urandom));
            step(1'b0);
        end

        // Random mixed traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if ($urandom_range(1) == 1) begin
                    case ($urandom_range(15))
                        0:       a = 64'h1000 + 64'($urandom_range(7));
                        1:       a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
                        default: a = 64'($urandom_range(63));
                    endcase
                    stage(i, 1'($urandom_range(1)), a, 8'($urandom));
                end
            end
            step(1'b0);
        end
        repeat (LAT + 1) step(1'b0);

        // 6: reset drops in-flight reads, storage survives
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_LANES; i++) stage(i, 1'b0, 64'h100 + 64'(i), 8'h00);
            step(k == 2);
            if (k == 2) check("t6_busy_after_reset", 64'(bus.busy), 64'h0);
        end
        for (int k = 0; k < LAT + 4; k++) begin
            step(1'b0);
            check("t6_no_valid", 64'(bus.rsp_valid), 64'h0);
        end
        for (int i = 0; i < NUM_LANES; i++) stage(i, 1'b0, 64'h100 + 64'(i), 8'h00);
        step(1'b0);
        wait_lat();
        check("t6_valid", 64'(bus.rsp_valid), 64'hFF);
        for (int i = 0; i < NUM_LANES; i++)
            check($sformatf("t6_data[%0d]", i), bus.rsp_data[i], 64'h10 + 64'(i));
        repeat (2) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_lane_responder.md
Name: dram_lane_responder

Overview:
- Responder end of the 8-byte-lane DRAM request interface driven by the copy/DMA engines.
- Per lane it accepts independent byte read/write requests, stores bytes in an internal byte-addressed array, and returns read data on per-lane valid strobes after a fixed pipeline latency.
- Used as the on-chip scratch DRAM and as the bench memory model for initiators.

Parameters:
- DEPTH, 4096, bytes of storage (power of two).
- BASE_ADDR, 64'h0, first byte address served.
- READ_LAT, 4, cycles from request edge to rsp_valid (legal 1..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_en  in  8  per-lane request strobe, one-cycle pulse
- req_we  in  8  per-lane write select (1 = write, 0 = read), qualified by req_en
- req_addr  in  8x64  per-lane byte address
- req_wdata  in  8x8  per-lane write byte
- rsp_valid  out  8  per-lane read-data valid pulse
- rsp_data  out  8x64  per-lane read data, byte zero-extended into bits [7:0]
- rsp_err  out  8  per-lane out-of-range flag, coincident with rsp_valid
- wr_err  out  1  pulses the cycle after any lane writes out of range
- busy  out  1  high while any read is in flight

Behaviour:
- Reset, synchronous, active-high: rsp_valid=0, rsp_data=0, rsp_err=0, wr_err=0, busy=0; all pipeline valid bits cleared. Storage contents are not cleared.
- Reset mid-operation drops all in-flight reads; no rsp_valid is produced for them.
- Range check: offset = req_addr - BASE_ADDR.
  - In range iff req_addr >= BASE_ADDR and offset < DEPTH. Use the full 64-bit compare; no wrap.
  - Index = offset[log2(DEPTH)-1:0].
- Write (req_en[i] & req_we[i]):
  - In range: byte is stored at the clock edge; no response.
  - Out of range: write is dropped and wr_err pulses high one cycle later.
- Read (req_en[i] & ~req_we[i]):
  - Byte is sampled at the request edge and shifted through a READ_LAT-deep per-lane pipeline (valid, err and data).
  - rsp_valid[i] is high exactly READ_LAT cycles after the request cycle, for one cycle.
  - Out of range: rsp_err[i]=1 and rsp_data[i]=0.
  - Fully pipelined: a new request can be accepted on every lane every cycle; no backpressure.
- rsp_data holds its last value when rsp_valid=0.
- Same-cycle read and write to the same byte, on any lanes: the read returns the old value (read-before-write).
- Same-cycle writes to the same byte from several lanes: the highest lane index wins.
- Writes in cycle N are visible to reads issued in cycle N+1 or later.
- busy = OR of all pipeline valid bits. It is 0 when READ_LAT cycles pass with no reads.
- Lanes are independent: any subset of req_en may be set in a cycle, and lanes may mix reads and writes in the same cycle.
- No state machine beyond the pipeline; responses return in request order per lane.

Decomposition:
- Shared package dram_pkg:
  - NUM_LANES=8, ADDR_W=64, LANE_W=8, RSP_W=64.
  - Typedefs lane_addr_t, lane_byte_t, lane_rsp_t.
  - Function in_range(addr, base, depth).
  - The existing copy engine migrates to these typedefs.
- Natural sub-module: dram_rd_pipe, the one-lane READ_LAT-deep shift pipeline of {valid, err, data}. It is instantiated 8 times; the top holds the storage array, the write-priority logic and busy.

Test Plan:
1. Reset then idle 10 cycles -> rsp_valid=0, busy=0, wr_err=0 every cycle.
2. Write bytes 0x10..0x17 to addresses 0x100..0x107 on lanes 0..7 in one cycle; read the same addresses next cycle -> rsp_valid=8'hFF exactly 4 cycles later, rsp_data[i]=0x10+i, rsp_err=0.
3. Lane 0 writes 0xAA to 0x20 while lane 1 reads 0x20 (prior value 0x55) -> lane 1 returns 0x55; a re-read returns 0xAA.
4. Lanes 2 and 5 both write 0x40 with 0x11 and 0x22 -> a subsequent read returns 0x22.
5. Read address 4096 (BASE 0, DEPTH 4096) on lane 3 -> rsp_valid[3]=1 and rsp_err[3]=1 with data 0 at +4 cycles. A write to 0xFFFF_FFFF_FFFF_FFFF -> wr_err pulses once.
6. Issue reads on 3 consecutive cycles, then assert reset on cycle 2 -> no rsp_valid afterwards, busy=0 the cycle after reset; earlier written data is intact on re-read.
